cmd_comm: RTL
=============

# cmd_comm

Host-side serial communications block for the oscilloscope digital core. It receives 8N1 UART bytes on `RX` and assembles each group of three into a 24-bit command, most significant byte first. It then presents the command to the core's command/config unit on a `cmd`/`cmd_rdy`/`clr_cmd_rdy` handshake. In the other direction it serialises single-byte responses requested via `send_resp`/`resp_data` onto `TX` and reports completion on `resp_sent`.

## Interface
- `BAUD_DIV`, default 347: clk cycles per bit (40 MHz clk, 115200 baud); legal range 8..4095.
- `clk` in 1: system clock, 40 MHz.
- `rst_n` in 1: reset, asynchronous, active-low.
- `RX` in 1: serial in from host; asynchronous, idles high.
- `TX` out 1: serial out to host; idles high.
- `cmd` out 24: assembled command; byte 1 in [23:16], byte 2 in [15:8], byte 3 in [7:0].
- `cmd_rdy` out 1: command valid; held high until cleared.
- `clr_cmd_rdy` in 1: one-cycle pulse from the core to release the command.
- `resp_data` in 8: response byte, sampled when `send_resp` is accepted.
- `send_resp` in 1: one-cycle pulse to start a response.
- `resp_sent` out 1: one-cycle pulse when the stop bit has completed.
- `frame_err` out 1: one-cycle pulse when a received stop bit reads 0.

## Operation
- Reset values: `TX`=1, `cmd`=0, `cmd_rdy`=0, `resp_sent`=0, `frame_err`=0. The byte counter resets to 0 and both FSMs reset to IDLE.
- `RX` passes through a 2-flop synchroniser before use. All receive logic acts on the synchronised value.
- RX FSM:
  - IDLE: a falling edge moves to START. The baud counter loads `BAUD_DIV/2` (integer division).
  - START: when the counter expires, sample the line. If it reads 0, go to DATA with the counter set to `BAUD_DIV`. If it reads 1, treat it as a false start and return to IDLE.
  - DATA: sample every `BAUD_DIV` cycles, 8 samples, LSB first.
  - STOP: sample after one more `BAUD_DIV`. A sample of 1 makes the byte valid. A sample of 0 pulses `frame_err`, discards the byte, and clears the byte counter. Either way, return to IDLE.
- Command assembly:
  - A valid byte is written to `cmd` slot [23:16], [15:8] or [7:0] for byte counter value 0, 1 or 2.
  - On the third byte, `cmd_rdy` sets and the counter wraps to 0.
  - While `cmd_rdy`=1, valid bytes are dropped and neither `cmd` nor the counter changes.
  - `clr_cmd_rdy` clears `cmd_rdy` on the next edge and leaves `cmd` unchanged.
  - If a valid byte and `clr_cmd_rdy` occur in the same cycle while `cmd_rdy`=1, the byte is dropped.
- TX FSM:
  - IDLE: `send_resp` latches `resp_data` into the shift register and moves to START.
  - START, DATA (8 bits, LSB first), STOP: each state lasts `BAUD_DIV` cycles.
  - At the end of STOP, pulse `resp_sent` and return to IDLE.
  - `send_resp` while not IDLE is ignored, and `resp_data` is not re-sampled.
- RX and TX are fully independent (full duplex).

## Timing
- TX: `TX` falls on the first edge after the cycle in which `send_resp` is sampled.
  - Each bit is exactly `BAUD_DIV` cycles.
  - `resp_sent` is high for one cycle, `10*BAUD_DIV` cycles after `TX` fell, coinciding with the first idle cycle.
  - The earliest next `send_resp` is accepted in that same cycle.
- RX latency: `cmd_rdy` rises 1 cycle after the third byte's stop-bit sample, which is about 9.5 bit times plus 2 synchroniser cycles after that byte's start edge.
- `frame_err` is asserted in the cycle following the failed stop sample.
- The baud counter is registered: it counts down to 1, and a load from 0 never occurs.
- Reset asserted mid-frame aborts both FSMs immediately: `TX` goes to 1, partial bytes are lost and the counter goes to 0.

## Structure
- Shared package `scope_pkg`:
  - `rx_state_t` and `tx_state_t` enums (IDLE, START, DATA, STOP).
  - Command opcode localparams DUMP_CH=8'h01 through EEP_RD=8'h09, shared with the command/config unit.
- Sub-module `uart_rx_byte` contains the synchroniser, RX FSM and baud counter. Its outputs are `rx_data[7:0]`, `rx_valid` and `rx_ferr`.
- TX FSM and command assembly live in `cmd_comm`.

## Test plan
All scenarios use `BAUD_DIV`=16.
- Host sends 0x02, 0x09, 0x00 → `cmd`=24'h020900 and `cmd_rdy`=1. Pulse `clr_cmd_rdy` → `cmd_rdy`=0 on the next cycle, `cmd` unchanged.
- While `cmd_rdy`=1, send 0x04, 0x00, 0x80 → all dropped, `cmd` unchanged. After clear, send 0x04, 0x01, 0x00 → `cmd`=24'h040100.
- Send 0x06, then a byte with stop bit 0, then 0x03, 0x00, 0x64 → one `frame_err` pulse, `cmd`=24'h030064.
- An 8-cycle low glitch on `RX` → no byte, no `frame_err`, counter stays at 0.
- `send_resp` with `resp_data`=8'hA5 → `TX` shows 0,1,0,1,0,0,1,0,1,1 for 16 cycles each. `resp_sent` pulses exactly 160 cycles after `TX` falls. A second `send_resp` mid-frame is ignored.
- Assert `rst_n` low during byte 2 of a command and during a TX frame → `TX`=1, `cmd_rdy`=0. A following complete 3-byte command assembles correctly.

Source files
------------

// File: rtl/scope_pkg.sv
// scope_pkg: shared FSM state types and command opcodes for the scope digital core
package scope_pkg;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  localparam logic [7:0] DUMP_CH    = 8'h01;
  localparam logic [7:0] CFG_GAIN   = 8'h02;
  localparam logic [7:0] TRIG_LVL   = 8'h03;
  localparam logic [7:0] TRIG_POS   = 8'h04;
  localparam logic [7:0] SET_DEC    = 8'h05;
  localparam logic [7:0] TRIG_CFG   = 8'h06;
  localparam logic [7:0] CFG_OFFSET = 8'h07;
  localparam logic [7:0] EEP_WR     = 8'h08;
  localparam logic [7:0] EEP_RD     = 8'h09;
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: synchronised 8N1 receiver producing one byte per valid stop bit
module uart_rx_byte import scope_pkg::*; #(
  parameter int BAUD_DIV = 347
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr
);
  rx_state_t   state;
  logic        rx_meta, rx_s, rx_d;
  logic [11:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  sh;
  logic        tick;
  assign tick = cnt == 12'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= RX_IDLE;
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_d     <= 1'b1;
      cnt      <= 12'd0;
      bit_idx  <= 3'd0;
      sh       <= 8'd0;
      rx_data  <= 8'd0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_meta  <= RX;
      rx_s     <= rx_meta;
      rx_d     <= rx_s;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (state != RX_IDLE) cnt <= tick ? 12'(BAUD_DIV) : cnt - 12'd1;
      case (state)
        RX_IDLE:
          if (rx_d && !rx_s) begin
            state <= RX_START;
            cnt   <= 12'(BAUD_DIV / 2);
          end
        RX_START:
          if (tick) begin
            state   <= rx_s ? RX_IDLE : RX_DATA;
            bit_idx <= 3'd0;
          end
        RX_DATA:
          if (tick) begin
            sh      <= {rx_s, sh[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end
        RX_STOP:
          if (tick) begin
            rx_data  <= sh;
            rx_valid <= rx_s;
            rx_ferr  <= !rx_s;
            state    <= RX_IDLE;
          end
      endcase
    end
endmodule

// File: rtl/cmd_comm.sv
// cmd_comm: host UART link assembling 24-bit commands and sending 1-byte responses
module cmd_comm import scope_pkg::*; #(
  parameter int BAUD_DIV = 347
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp_data,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        frame_err
);
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [1:0]  byte_cnt;
  tx_state_t   tx_state;
  logic [11:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_sh;
  logic        tx_tick;
  assign tx_tick = tx_cnt == 12'd1;
  uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ferr (frame_err)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cmd      <= 24'd0;
      cmd_rdy  <= 1'b0;
      byte_cnt <= 2'd0;
    end else begin
      if (clr_cmd_rdy) cmd_rdy <= 1'b0;
      if (frame_err) byte_cnt <= 2'd0;
      else if (rx_valid && !cmd_rdy) begin
        cmd      <= byte_cnt == 2'd0 ? {rx_data, cmd[15:0]} :
                    byte_cnt == 2'd1 ? {cmd[23:16], rx_data, cmd[7:0]} : {cmd[23:8], rx_data};
        byte_cnt <= byte_cnt == 2'd2 ? 2'd0 : byte_cnt + 2'd1;
        if (byte_cnt == 2'd2) cmd_rdy <= 1'b1;
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      TX        <= 1'b1;
      tx_cnt    <= 12'd0;
      tx_bit    <= 3'd0;
      tx_sh     <= 8'd0;
      resp_sent <= 1'b0;
    end else begin
      resp_sent <= 1'b0;
      if (tx_state != TX_IDLE) tx_cnt <= tx_tick ? 12'(BAUD_DIV) : tx_cnt - 12'd1;
      case (tx_state)
        TX_IDLE:
          if (send_resp) begin
            tx_sh    <= resp_data;
            TX       <= 1'b0;
            tx_cnt   <= 12'(BAUD_DIV);
            tx_state <= TX_START;
          end
        TX_START:
          if (tx_tick) begin
            TX       <= tx_sh[0];
            tx_sh    <= tx_sh >> 1;
            tx_bit   <= 3'd0;
            tx_state <= TX_DATA;
          end
        TX_DATA:
          if (tx_tick) begin
            TX     <= tx_bit == 3'd7 ? 1'b1 : tx_sh[0];
            tx_sh  <= tx_sh >> 1;
            tx_bit <= tx_bit + 3'd1;
            if (tx_bit == 3'd7) tx_state <= TX_STOP;
          end
        TX_STOP:
          if (tx_tick) begin
            resp_sent <= 1'b1;
            tx_state  <= TX_IDLE;
          end
      endcase
    end
endmodule
